// File: rtl/control_unit_pkg.sv
// cpu_pkg: shared opcode encodings, IR field positions, FSM state and
// instruction-class enums, and the control-strobe bundle used by control_unit.
package cpu_pkg;

    // IR field positions
    localparam int unsigned IR_OP_MSB = 31;
    localparam int unsigned IR_OP_LSB = 27;
    localparam int unsigned IR_RA_MSB = 26;
    localparam int unsigned IR_RA_LSB = 23;
    localparam int unsigned IR_RB_MSB = 22;
    localparam int unsigned IR_RB_LSB = 19;
    localparam int unsigned IR_RC_MSB = 18;
    localparam int unsigned IR_RC_LSB = 15;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_BINARY,
        CL_UNARY,
        CL_MULDIV,
        CL_NOP,
        CL_HALT
    } op_class_t;

    // One bit per control strobe; alu_en gates the opcode onto ALU_op
    typedef struct packed {
        logic pc_out;
        logic zhi_out;
        logic zlo_out;
        logic mdr_out;
        logic r_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic zhi_in;
        logic zlo_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic alu_en;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/memory handshake and datapath control strobes.
// master = control unit (drives strobes), slave = datapath side.
interface control_unit_if;

    logic [31:0] IR;
    logic        MemDone;

    logic        PCout;
    logic        ZHighout;
    logic        Zlowout;
    logic        MDRout;
    logic        Rout;
    logic        PCin;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        HIin;
    logic        LOin;
    logic        ZHighIn;
    logic        ZLowIn;
    logic        Rin;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        IncPC;
    logic        Read;
    logic [4:0]  ALU_op;
    logic        Run;

    modport master (
        input  IR, MemDone,
        output PCout, ZHighout, Zlowout, MDRout, Rout,
        output PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin,
        output Gra, Grb, Grc, IncPC, Read, ALU_op, Run
    );

    modport slave (
        output IR, MemDone,
        input  PCout, ZHighout, Zlowout, MDRout, Rout,
        input  PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin,
        input  Gra, Grb, Grc, IncPC, Read, ALU_op, Run
    );

endinterface

// File: rtl/control_unit_decode.sv
// cu_decode: combinational opcode -> instruction class.
// Macro CU_MULDIV_EN: when undefined, mul/div are classed as nop.
module cu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic [OPW-1:0] opcode_i,
    output op_class_t      class_o
);

    // Classify the opcode; anything unlisted behaves as nop
    always_comb begin
        class_o = CL_NOP;
        case (opcode_i)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR),
            OPW'(OP_ROR), OPW'(OP_ROL), OPW'(OP_SHR), OPW'(OP_SHRA),
            OPW'(OP_SHL):                  class_o = CL_BINARY;
            OPW'(OP_NEG), OPW'(OP_NOT):    class_o = CL_UNARY;
`ifdef CU_MULDIV_EN
            OPW'(OP_MUL), OPW'(OP_DIV):    class_o = CL_MULDIV;
            OPW'(OP_NOP):                  class_o = CL_NOP;
`else
            OPW'(OP_MUL), OPW'(OP_DIV),
            OPW'(OP_NOP):                  class_o = CL_NOP;
`endif
            OPW'(OP_HALT):                 class_o = CL_HALT;
            default:                       class_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer issuing datapath strobes through
// fetch (T0-T2) and execute (T3-T6) T-states. Strobes are decoded from the
// registered state and the current IR. Macro CU_MULDIV_EN enables mul/div (T6).
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic           Clock,
    input  logic           Clear,
    control_unit_if.master bus
);

    logic [OPW-1:0] opcode;
    op_class_t      op_class;
    state_t         state_q;
    state_t         state_d;
    ctrl_t          ctrl;
    logic           unused_ir;

    assign opcode    = bus.IR[IR_OP_MSB -: OPW];
    // Register fields are consumed by the datapath through Gra/Grb/Grc
    assign unused_ir = ^{bus.IR[IR_RA_MSB:IR_RA_LSB], bus.IR[IR_RB_MSB:IR_RB_LSB],
                         bus.IR[IR_RC_MSB:IR_RC_LSB], bus.IR[IR_RC_LSB-1:0]};

    cu_decode #(.OPW(OPW)) u_decode (
        .opcode_i (opcode),
        .class_o  (op_class)
    );

    // Next-state selection: fetch waits on MemDone, execute length depends on class
    always_comb begin
        state_d = ST_RST;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = bus.MemDone ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                case (op_class)
                    CL_BINARY, CL_UNARY, CL_MULDIV: state_d = ST_T4;
                    CL_HALT:                        state_d = ST_HALT;
                    default:                        state_d = ST_T0;
                endcase
            end
            ST_T4:   state_d = (op_class == CL_UNARY) ? ST_T0 : ST_T5;
            ST_T5:   state_d = (op_class == CL_MULDIV) ? ST_T6 : ST_T0;
`ifdef CU_MULDIV_EN
            ST_T6:   state_d = ST_T0;
`endif
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // State register; Clear forces RST immediately
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe decode per state and instruction class
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.zlo_in = 1'b1;
            end
            ST_T1: begin
                ctrl.zlo_out = 1'b1;
                ctrl.pc_in   = 1'b1;
                ctrl.read    = 1'b1;
                ctrl.mdr_in  = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (op_class)
                    CL_BINARY: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.alu_en = 1'b1;
                        ctrl.zlo_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CL_BINARY: begin
                        ctrl.grc    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.alu_en = 1'b1;
                        ctrl.zlo_in = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.alu_en = 1'b1;
                        ctrl.zhi_in = 1'b1;
                        ctrl.zlo_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CL_BINARY: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl.zlo_out = 1'b1;
                        ctrl.lo_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef CU_MULDIV_EN
            ST_T6: begin
                ctrl.zhi_out = 1'b1;
                ctrl.hi_in   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.PCout    = ctrl.pc_out;
    assign bus.ZHighout = ctrl.zhi_out;
    assign bus.Zlowout  = ctrl.zlo_out;
    assign bus.MDRout   = ctrl.mdr_out;
    assign bus.Rout     = ctrl.r_out;
    assign bus.PCin     = ctrl.pc_in;
    assign bus.MARin    = ctrl.mar_in;
    assign bus.MDRin    = ctrl.mdr_in;
    assign bus.IRin     = ctrl.ir_in;
    assign bus.Yin      = ctrl.y_in;
    assign bus.HIin     = ctrl.hi_in;
    assign bus.LOin     = ctrl.lo_in;
    assign bus.ZHighIn  = ctrl.zhi_in;
    assign bus.ZLowIn   = ctrl.zlo_in;
    assign bus.Rin      = ctrl.r_in;
    assign bus.Gra      = ctrl.gra;
    assign bus.Grb      = ctrl.grb;
    assign bus.Grc      = ctrl.grc;
    assign bus.IncPC    = ctrl.inc_pc;
    assign bus.Read     = ctrl.read;
    assign bus.ALU_op   = ctrl.alu_en ? 5'(opcode) : 5'b00000;
    assign bus.Run      = (state_q != ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit. Per-cycle expected strobe
// vectors for each instruction are queued up front and popped at each negedge.
module tb_control_unit;

    localparam logic [25:0] M_PCOUT  = 26'h0000001;
    localparam logic [25:0] M_ZHOUT  = 26'h0000002;
    localparam logic [25:0] M_ZLOUT  = 26'h0000004;
    localparam logic [25:0] M_MDROUT = 26'h0000008;
    localparam logic [25:0] M_ROUT   = 26'h0000010;
    localparam logic [25:0] M_PCIN   = 26'h0000020;
    localparam logic [25:0] M_MARIN  = 26'h0000040;
    localparam logic [25:0] M_MDRIN  = 26'h0000080;
    localparam logic [25:0] M_IRIN   = 26'h0000100;
    localparam logic [25:0] M_YIN    = 26'h0000200;
    localparam logic [25:0] M_HIIN   = 26'h0000400;
    localparam logic [25:0] M_LOIN   = 26'h0000800;
    localparam logic [25:0] M_ZHIN   = 26'h0001000;
    localparam logic [25:0] M_ZLIN   = 26'h0002000;
    localparam logic [25:0] M_RIN    = 26'h0004000;
    localparam logic [25:0] M_GRA    = 26'h0008000;
    localparam logic [25:0] M_GRB    = 26'h0010000;
    localparam logic [25:0] M_GRC    = 26'h0020000;
    localparam logic [25:0] M_INCPC  = 26'h0040000;
    localparam logic [25:0] M_READ   = 26'h0080000;
    localparam logic [25:0] M_RUN    = 26'h0100000;

    localparam logic [25:0] E_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZLIN;
    localparam logic [25:0] E_T1 = M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [25:0] E_T2 = M_RUN | M_MDROUT | M_IRIN;

    logic clk;
    logic clear;
    int   n_cmp;
    int   n_err;
    logic [25:0] exp_q[$];

    control_unit_if cu_if ();

    control_unit #(.OPW(5)) dut (
        .Clock (clk),
        .Clear (clear),
        .bus   (cu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] sample();
        return {cu_if.ALU_op, cu_if.Run, cu_if.Read, cu_if.IncPC, cu_if.Grc, cu_if.Grb,
                cu_if.Gra, cu_if.Rin, cu_if.ZLowIn, cu_if.ZHighIn, cu_if.LOin, cu_if.HIin,
                cu_if.Yin, cu_if.IRin, cu_if.MDRin, cu_if.MARin, cu_if.PCin, cu_if.Rout,
                cu_if.MDRout, cu_if.Zlowout, cu_if.ZHighout, cu_if.PCout};
    endfunction

    // 0 binary, 1 unary, 2 mul/div, 3 nop, 4 halt
    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: return 0;
            5'b10001, 5'b10010:                     return 1;
`ifdef CU_MULDIV_EN
            5'b01111, 5'b10000:                     return 2;
`endif
            5'b11011:                               return 4;
            default:                                return 3;
        endcase
    endfunction

    task automatic check(input logic [25:0] obs, input logic [25:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected vectors for one instruction, then step through it
    task automatic run_instr(input logic [31:0] ir, input int unsigned lows,
                             input int unsigned halt_cycles, input int unsigned abort_after,
                             input string tag);
        logic [4:0]  op;
        logic [25:0] alu;
        logic [25:0] obs;
        int          cls;
        int unsigned n;
        int unsigned irin_cnt;
        int unsigned drives;
        op  = ir[31:27];
        alu = {op, 21'h0};
        cls = op_class(op);
        exp_q.push_back(E_T0);
        for (int unsigned i = 0; i <= lows; i++) exp_q.push_back(E_T1);
        exp_q.push_back(E_T2);
        case (cls)
            0: begin
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZLIN | alu);
                exp_q.push_back(M_RUN | M_ZLOUT | M_GRA | M_RIN);
            end
            1: begin
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZLIN | alu);
                exp_q.push_back(M_RUN | M_ZLOUT | M_GRA | M_RIN);
            end
            2: begin
                exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZHIN | M_ZLIN | alu);
                exp_q.push_back(M_RUN | M_ZLOUT | M_LOIN);
                exp_q.push_back(M_RUN | M_ZHOUT | M_HIIN);
            end
            4: begin
                exp_q.push_back(M_RUN);
                for (int unsigned i = 0; i < halt_cycles; i++) exp_q.push_back(26'h0);
            end
            default: exp_q.push_back(M_RUN);
        endcase
        n = exp_q.size();
        irin_cnt = 0;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            obs = sample();
            check(obs, exp_q.pop_front(), tag);
            drives = 32'(obs[0]) + 32'(obs[1]) + 32'(obs[2]) + 32'(obs[3]) + 32'(obs[4]);
            check({25'h0, drives <= 1}, 26'h1, {tag, "_busdrive"});
            irin_cnt += 32'(obs[8]);
            if (k >= 1 && k <= 1 + lows) cu_if.MemDone = (k == 1 + lows);
            else                          cu_if.MemDone = 1'($urandom_range(0, 1));
            if (abort_after != 0 && k + 1 == abort_after) break;
            if (k == 2 + lows) begin
                @(posedge clk);
                #1 cu_if.IR = ir;
            end
        end
        if (abort_after != 0) exp_q.delete();
        else check(26'(irin_cnt), 26'd1, {tag, "_irin_once"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear = 1'b0;
        cu_if.IR = 32'h0;
        cu_if.MemDone = 1'b0;

        @(negedge clk);
        check(sample(), M_RUN, "reset");
        clear = 1'b1;

        run_instr(32'h28918000, 0, 0, 0, "and_r1_r2_r3");
        run_instr(32'h18918000, 3, 0, 0, "add_wait3");
        run_instr(32'h20918000, 1, 0, 0, "sub");
        run_instr(32'h58918000, 0, 0, 0, "shl");
        run_instr(32'h93380000, 0, 0, 0, "not_r6_r7");
        run_instr(32'h88918000, 2, 0, 0, "neg");
        run_instr(32'h7A280000, 0, 0, 0, "mul_r4_r5");
        run_instr(32'h80918000, 1, 0, 0, "div");
        run_instr(32'hD0000000, 0, 0, 0, "nop");
        run_instr(32'h00000000, 0, 0, 0, "unlisted_00000");
        run_instr(32'hF8000000, 0, 0, 0, "unlisted_11111");

        run_instr(32'h28918000, 0, 0, 5, "and_abort_t4");
        clear = 1'b0;
        #1 check(sample(), M_RUN, "clear_async_t4");
        @(negedge clk);
        check(sample(), M_RUN, "clear_held");
        clear = 1'b1;
        run_instr(32'h38918000, 0, 0, 0, "ror_after_clear");

        run_instr(32'hD8000000, 1, 20, 0, "halt");
        clear = 1'b0;
        #1 check(sample(), M_RUN, "halt_clear");
        @(negedge clk);
        clear = 1'b1;
        run_instr(32'h40918000, 0, 0, 0, "rol_after_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
